// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side memory for the M-stage port.
//   - word-addressed RAM (DEPTH x 32) at address 0
//   - 256-byte MMIO window at MMIO_BASE: GPIO output plus a compare timer
// Loads are combinational (zero latency); stores commit on the rising edge.
// Build option: define DMEM_MMIO_TIMER_EN to include the CNT/CMP/CTRL/STAT
// timer registers; without it those offsets read 0 and o_timer_irq is 0.
module data_mem_mmio #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_MemWrite,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WriteData,
  output logic [31:0] o_ReadData,
  output logic [31:0] o_gpio,
  output logic        o_timer_irq
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  // MMIO word offsets (i_Addr[7:2])
  localparam logic [5:0] REG_GPIO = 6'h00;
`ifdef DMEM_MMIO_TIMER_EN
  localparam logic [5:0] REG_CNT  = 6'h01;
  localparam logic [5:0] REG_CMP  = 6'h02;
  localparam logic [5:0] REG_CTRL = 6'h03;
  localparam logic [5:0] REG_STAT = 6'h04;
`endif

  logic [31:0]   mem [DEPTH];
  logic          ram_hit;
  logic          mmio_hit;
  logic          ram_we;
  logic          mmio_we;
  logic [AW-1:0] ram_idx;
  logic [5:0]    reg_sel;
  logic [31:0]   gpio;
  logic [31:0]   rdata;
  logic          addr_lsb_unused;

  // Word access only: byte-lane bits carry no meaning here.
  assign addr_lsb_unused = ^i_Addr[1:0];

  // Address decode; RAM takes precedence should the regions ever overlap.
  assign ram_hit  = ({1'b0, i_Addr} < RAM_BYTES);
  assign mmio_hit = !ram_hit && (i_Addr[31:8] == MMIO_BASE[31:8]);
  assign ram_idx  = i_Addr[AW+1:2];
  assign reg_sel  = i_Addr[7:2];
  assign ram_we   = i_MemWrite && ram_hit;
  assign mmio_we  = i_MemWrite && mmio_hit;

  // RAM store port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= i_WriteData;
    end
  end

  // GPIO output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio <= '0;
    end else if (mmio_we && (reg_sel == REG_GPIO)) begin
      gpio <= i_WriteData;
    end
  end

  assign o_gpio = gpio;

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic [2:0]  ctrl;   // {IE, AR, EN}
  logic        match;
  logic        hit;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_ctrl;
  logic        wr_stat;

  assign hit     = ctrl[0] && (cnt == cmp);
  assign wr_cnt  = mmio_we && (reg_sel == REG_CNT);
  assign wr_cmp  = mmio_we && (reg_sel == REG_CMP);
  assign wr_ctrl = mmio_we && (reg_sel == REG_CTRL);
  assign wr_stat = mmio_we && (reg_sel == REG_STAT);

  // Timer registers: CPU write to CNT beats increment/reload; a new match beats W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      cmp   <= '0;
      ctrl  <= '0;
      match <= 1'b0;
    end else begin
      if (wr_cnt) begin
        cnt <= i_WriteData;
      end else if (ctrl[0]) begin
        cnt <= (hit && ctrl[1]) ? '0 : cnt + 32'd1;
      end
      if (wr_cmp) begin
        cmp <= i_WriteData;
      end
      if (wr_ctrl) begin
        ctrl <= i_WriteData[2:0];
      end
      if (hit) begin
        match <= 1'b1;
      end else if (wr_stat && i_WriteData[0]) begin
        match <= 1'b0;
      end
    end
  end

  assign o_timer_irq = match & ctrl[2];
`else
  assign o_timer_irq = 1'b0;
`endif

  // Load mux: combinational from the address and current state.
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_GPIO: rdata = gpio;
`ifdef DMEM_MMIO_TIMER_EN
        REG_CNT:  rdata = cnt;
        REG_CMP:  rdata = cmp;
        REG_CTRL: rdata = {29'b0, ctrl};
        REG_STAT: rdata = {31'b0, match};
`endif
        default:  rdata = '0;
      endcase
    end
  end

  assign o_ReadData = rdata;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Testbench for data_mem_mmio: directed stimulus, a spec-level reference model
// compared every cycle, and hand-computed literal expectations.
// Timer checks are built only when DMEM_MMIO_TIMER_EN is defined.
module tb_data_mem_mmio;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] RAM_END   = 32'(DEPTH * 4);
  localparam logic [31:0] GPIO_A    = MMIO_BASE + 32'h00;
  localparam logic [31:0] CNT_A     = MMIO_BASE + 32'h04;
  localparam logic [31:0] CMP_A     = MMIO_BASE + 32'h08;
  localparam logic [31:0] CTRL_A    = MMIO_BASE + 32'h0C;
  localparam logic [31:0] STAT_A    = MMIO_BASE + 32'h10;
`ifdef DMEM_MMIO_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] o_ReadData;
  logic [31:0] o_gpio;
  logic        o_timer_irq;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  logic [31:0] ar_seq [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

  data_mem_mmio #(
    .DEPTH(DEPTH),
    .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_MemWrite(we),
    .i_Addr(addr),
    .i_WriteData(wdata),
    .o_ReadData(o_ReadData),
    .o_gpio(o_gpio),
    .o_timer_irq(o_timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [int unsigned];
  logic [31:0] m_gpio  = '0;
  logic [31:0] m_cnt   = '0;
  logic [31:0] m_cmp   = '0;
  logic [2:0]  m_ctrl  = '0;
  logic        m_match = 1'b0;
  logic        m_hit;
  logic        m_mm;
  logic [7:0]  m_off;
  logic [31:0] n_cnt;
  logic        n_match;

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    logic [7:0] off;
    known = 1'b1;
    model_read = '0;
    off = a[7:0] & 8'hFC;
    if (a < RAM_END) begin
      if (m_ram.exists(a >> 2)) model_read = m_ram[a >> 2];
      else known = 1'b0;
    end else if ((a & ~32'hFF) == MMIO_BASE) begin
      case (off)
        8'h00: model_read = m_gpio;
        8'h04: model_read = TIMER ? m_cnt : 32'h0;
        8'h08: model_read = TIMER ? m_cmp : 32'h0;
        8'h0C: model_read = TIMER ? {29'b0, m_ctrl} : 32'h0;
        8'h10: model_read = TIMER ? {31'b0, m_match} : 32'h0;
        default: model_read = '0;
      endcase
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_gpio = '0; m_cnt = '0; m_cmp = '0; m_ctrl = '0; m_match = 1'b0;
    end else begin
      m_mm  = !(addr < RAM_END) && ((addr & ~32'hFF) == MMIO_BASE);
      m_off = addr[7:0] & 8'hFC;
      m_hit = TIMER && m_ctrl[0] && (m_cnt == m_cmp);
      n_cnt = m_cnt;
      if (m_ctrl[0]) n_cnt = (m_hit && m_ctrl[1]) ? 32'h0 : m_cnt + 32'd1;
      n_match = m_match;
      if (we && m_mm && m_off == 8'h10 && wdata[0] && TIMER) n_match = 1'b0;
      if (m_hit) n_match = 1'b1;
      if (we) begin
        if (addr < RAM_END) m_ram[addr >> 2] = wdata;
        else if (m_mm) begin
          case (m_off)
            8'h00: m_gpio = wdata;
            8'h04: if (TIMER) n_cnt = wdata;
            8'h08: if (TIMER) m_cmp = wdata;
            8'h0C: if (TIMER) m_ctrl = wdata[2:0];
            default: ;
          endcase
        end
      end
      m_cnt   = n_cnt;
      m_match = n_match;
    end
  end

  // Every-cycle comparison against the model, after inputs have settled.
  always @(negedge clk) begin
    logic [31:0] e;
    bit k;
    #1;
    if (cmp_on) begin
      e = model_read(addr, k);
      if (k) check("model_rdata", o_ReadData, e);
      check("model_gpio", o_gpio, m_gpio);
      check("model_irq", {31'b0, o_timer_irq}, {31'b0, m_match & m_ctrl[2]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic peek(input string n, input logic [31:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a;
    #2;
    check(n, o_ReadData, exp);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_gpio", o_gpio, 32'h0);
    check("rst_irq", {31'b0, o_timer_irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cmp_on = 1'b1;

    // RAM store/load
    tick(1'b1, 32'h10, 32'h1111_1111);
    we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    #2;
    check("ram_same_cycle_old", o_ReadData, 32'h1111_1111);
    @(negedge clk);
    peek("ram_load", 32'h10, 32'hDEAD_BEEF);
    peek("ram_load_lowbits", 32'h13, 32'hDEAD_BEEF);
    tick(1'b1, 32'h14, 32'h0BAD_F00D);
    peek("ram_neighbor", 32'h10, 32'hDEAD_BEEF);
    peek("ram_word5", 32'h14, 32'h0BAD_F00D);
    tick(1'b1, RAM_END - 32'd4, 32'h7777_0001);
    peek("ram_last_word", RAM_END - 32'd1, 32'h7777_0001);

    // Unmapped
    tick(1'b1, RAM_END, 32'h1234);
    peek("unmapped_ram_end", RAM_END, 32'h0);
    tick(1'b1, MMIO_BASE - 32'd4, 32'h5555);
    peek("unmapped_below_mmio", MMIO_BASE - 32'd4, 32'h0);
    peek("ram_after_unmapped", RAM_END - 32'd4, 32'h7777_0001);

    // GPIO and asynchronous reset
    we = 1'b1; addr = GPIO_A; wdata = 32'hA5A5_0F0F;
    #2;
    check("gpio_before_edge", o_gpio, 32'h0);
    @(negedge clk);
    check("gpio_after_edge", o_gpio, 32'hA5A5_0F0F);
    peek("gpio_readback", GPIO_A + 32'd2, 32'hA5A5_0F0F);
    we = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("gpio_async_reset", o_gpio, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    peek("ram_survives_reset", 32'h10, 32'hDEAD_BEEF);

`ifdef DMEM_MMIO_TIMER_EN
    // Compare match with irq
    tick(1'b1, CMP_A, 32'd5);
    tick(1'b1, CTRL_A, 32'b101);
    for (int k = 0; k <= 6; k++) begin
      we = 1'b0; addr = CNT_A;
      #2;
      check("cnt_count", o_ReadData, 32'(k));
      check("irq_on_match", {31'b0, o_timer_irq}, {31'b0, (k == 6)});
      @(negedge clk);
    end
    we = 1'b1; addr = STAT_A; wdata = 32'h1;
    #2;
    check("irq_before_w1c", {31'b0, o_timer_irq}, 32'h1);
    @(negedge clk);
    we = 1'b0;
    #2;
    check("irq_after_w1c", {31'b0, o_timer_irq}, 32'h0);

    // Auto-reload
    tick(1'b1, CTRL_A, 32'h0);
    tick(1'b1, CNT_A, 32'h0);
    tick(1'b1, CMP_A, 32'd3);
    tick(1'b1, CTRL_A, 32'b011);
    for (int k = 0; k < 6; k++) begin
      we = 1'b0; addr = CNT_A;
      #2;
      check("cnt_autoreload", o_ReadData, ar_seq[k]);
      @(negedge clk);
    end
    peek("stat_after_ar", STAT_A, 32'h1);          // cnt 2 -> 3
    tick(1'b1, STAT_A, 32'h1);                      // cnt==3 match: set wins
    peek("stat_w1c_vs_match", STAT_A, 32'h1);      // cnt 0 -> 1
    tick(1'b1, STAT_A, 32'h1);                      // cnt 1 -> 2, clears
    peek("stat_cleared", STAT_A, 32'h0);           // cnt 2 -> 3
    tick(1'b1, CNT_A, 32'h100);                     // match cycle, write wins
    peek("cnt_write_wins", CNT_A, 32'h100);
    peek("stat_set_on_write", STAT_A, 32'h1);

    // Wrap
    tick(1'b1, CMP_A, 32'h10);
    tick(1'b1, CNT_A, 32'hFFFF_FFFF);
    peek("cnt_max", CNT_A, 32'hFFFF_FFFF);
    peek("cnt_wrap", CNT_A, 32'h0);
    peek("ctrl_readback", CTRL_A, 32'h3);
    peek("cmp_readback", CMP_A, 32'h10);

    // Reset mid-count
    tick(1'b1, CTRL_A, 32'b111);
    we = 1'b0; addr = CNT_A;
    #3;
    rst = 1'b0;
    #1;
    check("cnt_async_reset", o_ReadData, 32'h0);
    check("irq_async_reset", {31'b0, o_timer_irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    peek("cnt_held_after_reset", CNT_A, 32'h0);
    peek("cnt_held_again", CNT_A, 32'h0);
    peek("ctrl_after_reset", CTRL_A, 32'h0);
    tick(1'b1, CTRL_A, 32'b001);
    peek("cnt_restart0", CNT_A, 32'h0);
    peek("cnt_restart1", CNT_A, 32'h1);
`else
    // Timer not built
    tick(1'b1, CMP_A, 32'd5);
    tick(1'b1, CTRL_A, 32'b101);
    for (int k = 0; k < 8; k++) begin
      we = 1'b0; addr = CNT_A;
      #2;
      check("cnt_disabled", o_ReadData, 32'h0);
      check("irq_disabled", {31'b0, o_timer_irq}, 32'h0);
      @(negedge clk);
    end
    peek("ctrl_disabled", CTRL_A, 32'h0);
    peek("cmp_disabled", CMP_A, 32'h0);
    tick(1'b1, CNT_A, 32'h7);
    peek("cnt_write_ignored", CNT_A, 32'h0);
    peek("stat_disabled", STAT_A, 32'h0);
    peek("gpio_unchanged", GPIO_A, 32'h0);
`endif

    we = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
